div_unit: RTL and testbench

//   Iterative RV32M divider in the execute stage, directly downstream of the register file.

---
 rtl/div_unit.sv | 105 ++++++++++
 tb/tb_div_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative RV32M radix-2 restoring divider (DIV/DIVU/REM/REMU) with
// valid/ready handshakes on both sides and an optional one-cycle early out.
module div_unit #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1_rdata,
  input  logic [31:0] i_rs2_rdata,
  input  logic [4:0]  i_rd_waddr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd_waddr
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e      state_q;
  logic        ready_q, valid_q, rem_op_q, neg_q, fin_q;
  logic [4:0]  cnt_q, tag_q;
  logic [31:0] quo_q, rem_q, dvs_q, result_q;
  logic        sgn, a_neg, b_neg, div0, ovf, take;
  logic [31:0] a_abs, b_abs, early_res, mag, fixed;
  logic [32:0] trial, diff;
  always_comb begin
    sgn       = ~i_op[0];
    a_neg     = sgn & i_rs1_rdata[31];
    b_neg     = sgn & i_rs2_rdata[31];
    a_abs     = a_neg ? -i_rs1_rdata : i_rs1_rdata;
    b_abs     = b_neg ? -i_rs2_rdata : i_rs2_rdata;
    div0      = i_rs2_rdata == 32'd0;
    ovf       = sgn && i_rs1_rdata == 32'h8000_0000 && i_rs2_rdata == 32'hFFFF_FFFF;
    early_res = div0 ? (i_op[1] ? i_rs1_rdata : 32'hFFFF_FFFF) : (i_op[1] ? 32'd0 : 32'h8000_0000);
    trial     = {rem_q, quo_q[31]};
    diff      = trial - {1'b0, dvs_q};
    take      = ~diff[32];
    mag       = rem_op_q ? rem_q : quo_q;
    fixed     = neg_q ? -mag : mag;
  end
  // A zero divisor leaves the all-ones quotient unsigned-looking, so its negation is suppressed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
      rem_op_q <= 1'b0;
      neg_q    <= 1'b0;
      fin_q    <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
    end else if (i_flush) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_valid && ready_q) begin
          ready_q  <= 1'b0;
          tag_q    <= i_rd_waddr;
          rem_op_q <= i_op[1];
          neg_q    <= i_op[1] ? a_neg : (a_neg ^ b_neg) & ~div0;
          quo_q    <= a_abs;
          rem_q    <= '0;
          dvs_q    <= b_abs;
          cnt_q    <= '0;
          fin_q    <= 1'b0;
          if (EARLY_OUT && (div0 || ovf)) begin
            state_q  <= DONE;
            valid_q  <= 1'b1;
            result_q <= early_res;
          end else begin
            state_q <= BUSY;
          end
        end
        BUSY: if (fin_q) begin
          state_q  <= DONE;
          valid_q  <= 1'b1;
          result_q <= fixed;
        end else begin
          rem_q <= take ? diff[31:0] : trial[31:0];
          quo_q <= {quo_q[30:0], take};
          cnt_q <= cnt_q + 5'd1;
          fin_q <= cnt_q == 5'd31;
        end
        DONE: if (i_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_result   = result_q;
  assign o_rd_waddr = tag_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: drives an EARLY_OUT=1 and an EARLY_OUT=0 divider in lockstep and
// checks results, tags, latency and handshake behaviour against an arithmetic model.
module tb_div_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, flush, valid, ready_in;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [4:0]  tag;
  logic        rdy1, vld1, rdy0, vld0;
  logic [31:0] res1, res0;
  logic [4:0]  tag1, tag0;
  int checks = 0, passes = 0;

  div_unit #(.EARLY_OUT(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(rdy1),
    .i_op(op), .i_rs1_rdata(a), .i_rs2_rdata(b), .i_rd_waddr(tag),
    .o_valid(vld1), .i_ready(ready_in), .o_result(res1), .o_rd_waddr(tag1));
  div_unit #(.EARLY_OUT(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(rdy0),
    .i_op(op), .i_rs1_rdata(a), .i_rs2_rdata(b), .i_rd_waddr(tag),
    .o_valid(vld0), .i_ready(ready_in), .o_result(res0), .o_rd_waddr(tag0));

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'd0:    return $signed(x) / $signed(y);
      2'd1:    return x / y;
      2'd2:    return $signed(x) % $signed(y);
      default: return x % y;
    endcase
  endfunction

  function automatic bit special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return y == 32'd0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op to both units, waits for both results (bounded), then takes them.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t,
                       output logic [31:0] r1, output logic [31:0] r0, output logic [4:0] t1, output logic [4:0] t0,
                       output int l1, output int l0);
    bit g1 = 0, g0 = 0;
    l1 = 99; l0 = 99; r1 = 'x; r0 = 'x; t1 = 'x; t0 = 'x;
    @(negedge clk);
    valid = 1'b1; op = o; a = x; b = y; tag = t;
    @(posedge clk); #1;
    valid = 1'b0; a = $urandom; b = $urandom; tag = 5'($urandom);
    for (int k = 1; k <= 40 && !(g1 && g0); k++) begin
      @(posedge clk); #1;
      if (!g1 && vld1) begin g1 = 1; l1 = k; r1 = res1; t1 = tag1; end
      if (!g0 && vld0) begin g0 = 1; l0 = k; r0 = res0; t0 = tag0; end
    end
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if ({rdy1, rdy0} !== 2'b11) $display("FAIL reset_ready got %b exp 11", {rdy1, rdy0}); else passes++;
    checks++; if ({vld1, vld0} !== 2'b00) $display("FAIL reset_valid got %b exp 00", {vld1, vld0}); else passes++;
    checks++; if (res1 !== 32'd0 || tag1 !== 5'd0) $display("FAIL reset_outputs got %h/%0d exp 0/0", res1, tag1); else passes++;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [8] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
    logic [31:0] xs  [8] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd1234, 32'd1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] ys  [8] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [8] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1234, 32'h8000_0000, 32'd0};
    int          el  [8] = '{33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] r1, r0;
    logic [4:0]  t1, t0;
    int          l1, l0;
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], xs[i], ys[i], 5'(i + 5), r1, r0, t1, t0, l1, l0);
      checks++; if (r1 !== ex[i]) $display("FAIL dir%0d_result_early got %h exp %h", i, r1, ex[i]); else passes++;
      checks++; if (r0 !== ex[i]) $display("FAIL dir%0d_result_full got %h exp %h", i, r0, ex[i]); else passes++;
      checks++; if (t1 !== 5'(i + 5) || t0 !== 5'(i + 5)) $display("FAIL dir%0d_tag got %0d/%0d exp %0d", i, t1, t0, i + 5); else passes++;
      checks++; if (l1 != el[i] || l0 != 33) $display("FAIL dir%0d_latency got %0d/%0d exp %0d/33", i, l1, l0, el[i]); else passes++;
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, e, r1, r0;
    logic [1:0]  o;
    logic [4:0]  t, t1, t0;
    int          l1, l0;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom); x = pick(); y = pick(); t = 5'($urandom);
      e = model(o, x, y);
      do_op(o, x, y, t, r1, r0, t1, t0, l1, l0);
      checks++; if (r1 !== e || r0 !== e) $display("FAIL rnd%0d op%0d %h/%h got %h/%h exp %h", i, o, x, y, r1, r0, e); else passes++;
      checks++; if (t1 !== t || t0 !== t) $display("FAIL rnd%0d_tag got %0d/%0d exp %0d", i, t1, t0, t); else passes++;
      checks++; if (l1 != (special(o, x, y) ? 1 : 33) || l0 != 33) $display("FAIL rnd%0d_latency got %0d/%0d", i, l1, l0); else passes++;
    end
  endtask

  task automatic test_stall();
    bit seen = 0;
    @(negedge clk);
    valid = 1'b1; op = 2'd1; a = 32'd1000; b = 32'd10; tag = 5'd3;
    @(posedge clk); #1 valid = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      seen = vld1 && vld0;
    end
    checks++; if (!seen) $display("FAIL stall_wait got no valid exp valid within 40 cycles"); else passes++;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (!(vld1 && vld0 && res1 === 32'd100 && res0 === 32'd100 && tag1 === 5'd3 && !rdy1 && !rdy0))
        $display("FAIL stall_hold%0d got v%b%b r%h rdy%b%b exp v11 r64 rdy00", k, vld1, vld0, res1, rdy1, rdy0);
      else passes++;
    end
    ready_in = 1'b1;
    @(posedge clk); #1 ready_in = 1'b0;
    checks++; if ({vld1, vld0, rdy1, rdy0} !== 4'b0011) $display("FAIL stall_release got %b exp 0011", {vld1, vld0, rdy1, rdy0}); else passes++;
  endtask

  task automatic test_abort(input bit use_rst);
    bit          rose = 0;
    logic [31:0] r1, r0;
    logic [4:0]  t1, t0;
    int          l1, l0;
    @(negedge clk);
    valid = 1'b1; op = 2'd1; a = 32'd100; b = 32'd7; tag = 5'd9;
    @(posedge clk); #1 valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    valid = 1'b1; a = 32'd55; b = 32'd5; tag = 5'd4;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; valid = 1'b0;
    checks++; if ({rdy1, rdy0, vld1, vld0} !== 4'b1100) $display("FAIL abort%0d_idle got %b exp 1100", use_rst, {rdy1, rdy0, vld1, vld0}); else passes++;
    if (use_rst) begin
      checks++; if (res1 !== 32'd0 || res0 !== 32'd0 || tag1 !== 5'd0 || tag0 !== 5'd0)
        $display("FAIL abort_rst_outputs got %h/%h tag %0d/%0d exp 0", res1, res0, tag1, tag0); else passes++;
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (vld1 || vld0) rose = 1;
    end
    checks++; if (rose) $display("FAIL abort%0d_no_valid got valid exp none", use_rst); else passes++;
    do_op(2'd1, 32'd9, 32'd3, 5'd7, r1, r0, t1, t0, l1, l0);
    checks++; if (r1 !== 32'd3 || r0 !== 32'd3 || t1 !== 5'd7) $display("FAIL abort%0d_next got %h/%h tag %0d exp 3 tag 7", use_rst, r1, r0, t1); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r0;
    logic [4:0]  t1, t0;
    int          l1, l0;
    do_op(2'd0, 32'hFFFF_FF9C, 32'd9, 5'd1, r1, r0, t1, t0, l1, l0);
    checks++; if ({rdy1, rdy0} !== 2'b11) $display("FAIL b2b_ready got %b exp 11", {rdy1, rdy0}); else passes++;
    checks++; if (r1 !== 32'hFFFF_FFF5 || r0 !== 32'hFFFF_FFF5) $display("FAIL b2b_first got %h/%h exp fffffff5", r1, r0); else passes++;
    do_op(2'd2, 32'hFFFF_FF9C, 32'd9, 5'd2, r1, r0, t1, t0, l1, l0);
    checks++; if (r1 !== 32'hFFFF_FFFF || r0 !== 32'hFFFF_FFFF || t1 !== 5'd2) $display("FAIL b2b_second got %h/%h exp ffffffff", r1, r0); else passes++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0; ready_in = 1'b0;
    op = '0; a = '0; b = '0; tag = '0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
